// File: rtl/plic_pkg.sv
// plic_pkg: shared PLIC register map constants and the context-agent state type.
// Offsets are relative to the PLIC base (0x50000000) in 30-bit MMIO offset space.
package plic_pkg;

  localparam logic [29:0] PLIC_PRIO_BASE          = 30'h000000;
  localparam logic [29:0] PLIC_PEND_BASE          = 30'h001000;
  localparam logic [29:0] PLIC_ENABLE_BASE        = 30'h002000;
  localparam logic [29:0] PLIC_ENABLE_CTX_STRIDE  = 30'h000080;
  localparam logic [29:0] PLIC_THRESH_BASE        = 30'h200000;
  localparam logic [29:0] PLIC_CLAIM_BASE         = 30'h200004;
  localparam logic [29:0] PLIC_CTX_STRIDE         = 30'h001000;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM,
    CAPTURE,
    PRESENT,
    SERVICE,
    COMPLETE
  } agent_state_t;

  // Claim/complete register of context ctx.
  function automatic logic [29:0] claim_ofs(input int ctx);
    return PLIC_CLAIM_BASE + 30'(ctx) * PLIC_CTX_STRIDE;
  endfunction

endpackage

// File: rtl/plic_ctx_agent_if.sv
// plic_ctx_agent_if: simple MMIO bus (offset / write / read strobes, 1-cycle read data).
// The agent uses it twice: as slave toward the hart (CPU side) and as master toward the PLIC.
//   offset : 30-bit register offset      we/wdata : write strobe and data
//   re     : read strobe                 rdata    : read data, valid the cycle after offset
interface plic_ctx_agent_if;
  logic [29:0] offset;
  logic        we;
  logic [31:0] wdata;
  logic        re;
  logic [31:0] rdata;

  modport master (output offset, output we, output wdata, output re, input rdata);
  modport slave  (input offset, input we, input wdata, input re, output rdata);
endinterface

// File: rtl/plic_ctx_agent.sv
// plic_ctx_agent: hart-side initiator for one PLIC context.
// On w_eip it reads claim/complete, presents the claimed ID to the trap unit, waits for
// the handler to finish, then writes the ID back. CPU MMIO traffic is muxed through to
// the PLIC except in the single cycles where the agent owns the bus (CLAIM, COMPLETE);
// then a pending CPU access sees cpu_stall and must be held.
//
// Ports:
//   CLK, RST               clock, asynchronous active-high reset
//   w_eip                  PLIC external-interrupt pending for context CTX
//   cpu  (slave modport)   CPU MMIO request; cpu.rdata = plic.rdata
//   cpu_stall              CPU access not taken this cycle
//   plic (master modport)  bus toward the PLIC
//   irq_valid/irq_id/irq_ready   claimed-ID handshake to the trap unit
//   done_valid/done_id     handler-finished pulse with its ID
//   irq_err                1-cycle pulse: spurious done or service timeout
//
// Configuration: define PLIC_AGENT_TIMEOUT_EN to bound SERVICE to TIMEOUT cycles; a
// timeout pulses irq_err and forces the complete write. Without it SERVICE waits forever.
module plic_ctx_agent
  import plic_pkg::*;
#(
  parameter int CTX      = 0,
  parameter int W_INT_ID = 6,
  parameter int HOLDOFF  = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 w_eip,
  plic_ctx_agent_if.slave      cpu,
  output logic                 cpu_stall,
  plic_ctx_agent_if.master     plic,
  output logic                 irq_valid,
  output logic [W_INT_ID-1:0]  irq_id,
  input  logic                 irq_ready,
  input  logic                 done_valid,
  input  logic [W_INT_ID-1:0]  done_id,
  output logic                 irq_err
);

  localparam logic [29:0] CLAIM_OFS = claim_ofs(CTX);
  localparam int          HO_W      = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  agent_state_t        state;
  logic [W_INT_ID-1:0] id_q;
  logic [HO_W-1:0]     hold_cnt;
  // Registered bus-ownership flags: high exactly while state is CLAIM / COMPLETE.
  logic                claim_q;
  logic                compl_q;
  logic                irq_valid_q;
  logic                irq_err_q;
  logic [W_INT_ID-1:0] rd_id;

`ifdef PLIC_AGENT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TO_W-1:0] svc_cnt;
`endif

  assign rd_id = plic.rdata[W_INT_ID-1:0];

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      id_q        <= '0;
      hold_cnt    <= '0;
      claim_q     <= 1'b0;
      compl_q     <= 1'b0;
      irq_valid_q <= 1'b0;
      irq_err_q   <= 1'b0;
`ifdef PLIC_AGENT_TIMEOUT_EN
      svc_cnt     <= '0;
`endif
    end else begin
      irq_err_q <= 1'b0;
      claim_q   <= 1'b0;
      compl_q   <= 1'b0;

      if (hold_cnt != '0) hold_cnt <= hold_cnt - HO_W'(1);

      // A done outside SERVICE has no claim to finish: flag it and drop it.
      if (done_valid && (state != SERVICE)) irq_err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (w_eip && (hold_cnt == '0)) begin
            state   <= CLAIM;
            claim_q <= 1'b1;
          end
        end

        CLAIM: state <= CAPTURE;

        // Claim data arrives one cycle after the read; ID 0 means another
        // context won the race, so there is nothing to complete.
        CAPTURE: begin
          id_q <= rd_id;
          if (rd_id == '0) begin
            state <= IDLE;
          end else begin
            state       <= PRESENT;
            irq_valid_q <= 1'b1;
          end
        end

        PRESENT: begin
          if (irq_ready) begin
            state       <= SERVICE;
            irq_valid_q <= 1'b0;
`ifdef PLIC_AGENT_TIMEOUT_EN
            svc_cnt     <= '0;
`endif
          end
        end

        SERVICE: begin
          if (done_valid && (done_id == id_q)) begin
            state   <= COMPLETE;
            compl_q <= 1'b1;
          end else begin
            if (done_valid) irq_err_q <= 1'b1;
`ifdef PLIC_AGENT_TIMEOUT_EN
            if (svc_cnt == TO_W'(TIMEOUT - 1)) begin
              irq_err_q <= 1'b1;
              state     <= COMPLETE;
              compl_q   <= 1'b1;
            end else begin
              svc_cnt <= svc_cnt + TO_W'(1);
            end
`endif
          end
        end

        COMPLETE: begin
          state    <= IDLE;
          hold_cnt <= HO_W'(HOLDOFF);
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Bus mux: the agent overrides the PLIC side only in CLAIM and COMPLETE.
  // Strobes are forced low while RST is held.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    plic.offset = cpu.offset;
    plic.wdata  = cpu.wdata;
    plic.re     = cpu.re;
    plic.we     = cpu.we;
    cpu_stall   = 1'b0;

    if (claim_q) begin
      plic.offset = CLAIM_OFS;
      plic.re     = 1'b1;
      plic.we     = 1'b0;
      cpu_stall   = cpu.re | cpu.we;
    end else if (compl_q) begin
      plic.offset = CLAIM_OFS;
      plic.wdata  = 32'(id_q);
      plic.re     = 1'b0;
      plic.we     = 1'b1;
      cpu_stall   = cpu.re | cpu.we;
    end

    if (RST) begin
      plic.re = 1'b0;
      plic.we = 1'b0;
    end
  end

  assign cpu.rdata = plic.rdata;
  assign irq_valid = irq_valid_q;
  assign irq_id    = id_q;
  assign irq_err   = irq_err_q;

endmodule

// File: tb/tb_plic_ctx_agent.sv
// Directed self-checking bench for plic_ctx_agent (CTX=0, W_INT_ID=6, HOLDOFF=3, TIMEOUT=16).
// A small PLIC model returns claim_val on reads of the claim register and an
// offset-derived pattern elsewhere, one cycle after the read strobe.
module tb_plic_ctx_agent;

  localparam logic [29:0] CLAIM_OFS = 30'h200004;

  logic       CLK;
  logic       RST;
  logic       w_eip;
  logic       cpu_stall;
  logic       irq_valid;
  logic [5:0] irq_id;
  logic       irq_ready;
  logic       done_valid;
  logic [5:0] done_id;
  logic       irq_err;

  plic_ctx_agent_if cpu_bus ();
  plic_ctx_agent_if plic_bus ();

  plic_ctx_agent #(
    .CTX      (0),
    .W_INT_ID (6),
    .HOLDOFF  (3),
    .TIMEOUT  (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .w_eip      (w_eip),
    .cpu        (cpu_bus.slave),
    .cpu_stall  (cpu_stall),
    .plic       (plic_bus.master),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ready  (irq_ready),
    .done_valid (done_valid),
    .done_id    (done_id),
    .irq_err    (irq_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PLIC model and bus monitor.
  logic [31:0] claim_val;
  int          claim_cnt;
  int          wr_cnt;

  always @(posedge CLK) begin
    if (plic_bus.re) begin
      if (plic_bus.offset == CLAIM_OFS) plic_bus.rdata <= claim_val;
      else                              plic_bus.rdata <= {2'b00, plic_bus.offset} ^ 32'hA5A5_0000;
    end
    if (!RST && plic_bus.re && (plic_bus.offset == CLAIM_OFS)) claim_cnt <= claim_cnt + 1;
    if (!RST && plic_bus.we && (plic_bus.offset == CLAIM_OFS)) wr_cnt <= wr_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int cyc;
  bit found;

  initial begin
    plic_bus.rdata   = '0;
    claim_val        = '0;
    claim_cnt        = 0;
    wr_cnt           = 0;
    RST              = 1'b1;
    w_eip            = 1'b0;
    irq_ready        = 1'b0;
    done_valid       = 1'b0;
    done_id          = '0;
    cpu_bus.offset   = 30'h123;
    cpu_bus.we       = 1'b0;
    cpu_bus.wdata    = '0;
    cpu_bus.re       = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    settle();
    check("rst_irq_valid", 32'(irq_valid), 32'd0);
    check("rst_irq_err",   32'(irq_err),   32'd0);
    check("rst_stall",     32'(cpu_stall), 32'd0);
    check("rst_plic_re",   32'(plic_bus.re), 32'd0);
    check("rst_offset_passthru", 32'(plic_bus.offset), 32'h123);
    cpu_bus.re = 1'b0;
    tick();
    RST = 1'b0;

    // ---- claim of ID 5, service, complete ----
    claim_val = 32'd5;
    w_eip     = 1'b1;
    tick();                                 // CLAIM
    settle();
    check("claim_re",     32'(plic_bus.re),     32'd1);
    check("claim_we",     32'(plic_bus.we),     32'd0);
    check("claim_offset", 32'(plic_bus.offset), 32'(CLAIM_OFS));
    w_eip = 1'b0;                           // drop after claim: no effect
    tick();                                 // CAPTURE
    settle();
    check("capture_re",   32'(plic_bus.re), 32'd0);
    check("capture_valid", 32'(irq_valid),  32'd0);
    tick();                                 // PRESENT
    settle();
    check("present_valid", 32'(irq_valid), 32'd1);
    check("present_id",    32'(irq_id),    32'd5);
    check("claim_count",   32'(claim_cnt), 32'd1);
    tick();                                 // still PRESENT without ready
    settle();
    check("present_hold", 32'(irq_valid), 32'd1);
    irq_ready = 1'b1;
    tick();                                 // SERVICE
    irq_ready = 1'b0;
    settle();
    check("service_valid_low", 32'(irq_valid), 32'd0);
    done_valid = 1'b1;
    done_id    = 6'd5;
    tick();                                 // COMPLETE
    done_valid = 1'b0;
    w_eip      = 1'b1;
    settle();
    check("complete_we",     32'(plic_bus.we),     32'd1);
    check("complete_offset", 32'(plic_bus.offset), 32'(CLAIM_OFS));
    check("complete_wdata",  plic_bus.wdata,       32'd5);
    check("complete_err",    32'(irq_err),         32'd0);

    // ---- holdoff: eip held high, no claim for the holdoff cycles ----
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      check($sformatf("holdoff_re_%0d", i), 32'(plic_bus.re), 32'd0);
    end
    check("write_count", 32'(wr_cnt), 32'd1);

    // ---- spurious claim (ID 0) ----
    claim_val = 32'd0;
    tick();                                 // CLAIM after holdoff expired
    settle();
    check("reclaim_re", 32'(plic_bus.re), 32'd1);
    w_eip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      check($sformatf("spur_valid_%0d", i), 32'(irq_valid), 32'd0);
    end
    check("spur_no_write", 32'(wr_cnt), 32'd1);

    // ---- CPU read collides with CLAIM ----
    claim_val = 32'd9;
    w_eip     = 1'b1;
    tick();                                 // CLAIM
    w_eip          = 1'b0;
    cpu_bus.re     = 1'b1;
    cpu_bus.offset = 30'h40;
    settle();
    check("coll_stall",  32'(cpu_stall),       32'd1);
    check("coll_offset", 32'(plic_bus.offset), 32'(CLAIM_OFS));
    tick();                                 // CAPTURE: CPU request goes through
    settle();
    check("coll_stall_released", 32'(cpu_stall),       32'd0);
    check("coll_cpu_offset",     32'(plic_bus.offset), 32'h40);
    check("coll_cpu_re",         32'(plic_bus.re),     32'd1);
    tick();                                 // PRESENT
    cpu_bus.re = 1'b0;
    settle();
    check("coll_rdata", cpu_bus.rdata, 32'hA5A5_0040);
    check("coll_id",    32'(irq_id),   32'd9);

    // ---- mismatched done, then correct done; CPU write during COMPLETE ----
    irq_ready = 1'b1;
    tick();                                 // SERVICE
    irq_ready  = 1'b0;
    done_valid = 1'b1;
    done_id    = 6'd7;
    tick();
    done_valid = 1'b0;
    settle();
    check("bad_done_err",  32'(irq_err),     32'd1);
    check("bad_done_stay", 32'(plic_bus.we), 32'd0);
    tick();
    settle();
    check("bad_done_pulse", 32'(irq_err), 32'd0);
    done_valid = 1'b1;
    done_id    = 6'd9;
    tick();                                 // COMPLETE
    done_valid     = 1'b0;
    cpu_bus.we     = 1'b1;
    cpu_bus.offset = 30'h80;
    cpu_bus.wdata  = 32'hDEAD;
    settle();
    check("c9_we",    32'(plic_bus.we), 32'd1);
    check("c9_wdata", plic_bus.wdata,   32'd9);
    check("c9_stall", 32'(cpu_stall),   32'd1);
    tick();                                 // IDLE: CPU write passes
    settle();
    check("cpu_wr_offset", 32'(plic_bus.offset), 32'h80);
    check("cpu_wr_data",   plic_bus.wdata,       32'hDEAD);
    check("cpu_wr_stall",  32'(cpu_stall),       32'd0);
    cpu_bus.we = 1'b0;

    // ---- done outside SERVICE ----
    done_valid = 1'b1;
    done_id    = 6'd3;
    tick();
    done_valid = 1'b0;
    settle();
    check("idle_done_err", 32'(irq_err), 32'd1);
    tick();
    settle();
    check("idle_done_pulse", 32'(irq_err), 32'd0);
    check("write_count2", 32'(wr_cnt), 32'd2);

    // ---- service timeout ----
    claim_val = 32'd12;
    w_eip     = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      settle();
      if (plic_bus.re && (plic_bus.offset == CLAIM_OFS)) found = 1'b1;
    end
    check("to_claim_seen", 32'(found), 32'd1);
    w_eip = 1'b0;
    tick();                                 // CAPTURE
    tick();                                 // PRESENT
    settle();
    check("to_id", 32'(irq_id), 32'd12);
    irq_ready = 1'b1;
    tick();                                 // first SERVICE cycle
    irq_ready = 1'b0;
    settle();
    cyc = 0;
    while (!plic_bus.we && cyc < 40) begin
      tick();
      settle();
      cyc++;
    end
`ifdef PLIC_AGENT_TIMEOUT_EN
    check("to_cycles", 32'(cyc),      32'd16);
    check("to_err",    32'(irq_err),  32'd1);
    check("to_wdata",  plic_bus.wdata, 32'd12);
`else
    check("no_to_cycles", 32'(cyc),     32'd40);
    check("no_to_err",    32'(irq_err), 32'd0);
    done_valid = 1'b1;
    done_id    = 6'd12;
    tick();                                 // COMPLETE
    done_valid = 1'b0;
    settle();
    check("no_to_we",    32'(plic_bus.we), 32'd1);
    check("no_to_wdata", plic_bus.wdata,   32'd12);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
